// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream input and program RAM bus for prog_loader (r_addr/r_data with PROG_LOADER_VERIFY_EN)
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [7:0] w_addr;
    logic [7:0] w_data;
`ifdef PROG_LOADER_VERIFY_EN
    logic [7:0] r_addr;
    logic [7:0] r_data;
`endif

    modport master (
        input  in_valid, in_data,
`ifdef PROG_LOADER_VERIFY_EN
        input  r_data,
        output r_addr,
`endif
        output in_ready, we, w_addr, w_data
    );

    modport slave (
        output in_valid, in_data,
`ifdef PROG_LOADER_VERIFY_EN
        output r_data,
        input  r_addr,
`endif
        input  in_ready, we, w_addr, w_data
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream program RAM loader, optional readback verify under PROG_LOADER_VERIFY_EN
module prog_loader #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.master bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

`ifdef PROG_LOADER_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_VERIFY} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  base_q, base_d;
    logic [8:0]  len_q, len_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  xor_q, xor_d;
    logic [15:0] tmr_q, tmr_d;
    logic        we_q, we_d;
    logic [7:0]  w_addr_q, w_addr_d;
    logic [7:0]  w_data_q, w_data_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic        in_ready_w;
    logic        accept;
`ifdef PROG_LOADER_VERIFY_EN
    logic [7:0]  r_addr_q, r_addr_d;
    logic [8:0]  vidx_q, vidx_d;
    logic [7:0]  vxor_q, vxor_d;

    assign in_ready_w  = (state_q != S_VERIFY);
    assign bus.r_addr  = r_addr_q;
`else
    assign in_ready_w  = 1'b1;
`endif

    assign accept       = bus.in_valid && in_ready_w;
    assign bus.in_ready = in_ready_w;
    assign bus.we       = we_q;
    assign bus.w_addr   = w_addr_q;
    assign bus.w_data   = w_data_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = code_q;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        we_d     = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        hold_d   = hold_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = code_q;
`ifdef PROG_LOADER_VERIFY_EN
        r_addr_d = r_addr_q;
        vidx_d   = vidx_q;
        vxor_d   = vxor_q;
`endif
        // Idle-gap timer: only meaningful between frame bytes
        if (state_q == S_IDLE || accept) begin
            tmr_d = 16'd0;
        end else begin
            tmr_d = tmr_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (accept && bus.in_data == SYNC_BYTE) begin
                    state_d = S_ADDR;
                    hold_d  = 1'b1;
                end
            end
            S_ADDR: begin
                if (accept) begin
                    base_d  = bus.in_data;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d   = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
                    idx_d   = 9'd0;
                    xor_d   = 8'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d     = 1'b1;
                    w_addr_d = base_q + idx_q[7:0];
                    w_data_d = bus.in_data;
                    xor_d    = xor_q ^ bus.in_data;
                    idx_d    = idx_q + 9'd1;
                    if (idx_q == len_q - 9'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.in_data == xor_q) begin
`ifdef PROG_LOADER_VERIFY_EN
                        state_d  = S_VERIFY;
                        r_addr_d = base_q;
                        vidx_d   = 9'd0;
                        vxor_d   = 8'd0;
`else
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        hold_d  = 1'b0;
                    end
                end
            end
`ifdef PROG_LOADER_VERIFY_EN
            // LEN read cycles accumulate readback XOR, one extra cycle compares
            S_VERIFY: begin
                if (vidx_q == len_q) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b0;
                    if (vxor_q == xor_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d  = 1'b1;
                        code_d = 2'b11;
                    end
                end else begin
                    vxor_d   = vxor_q ^ bus.r_data;
                    r_addr_d = r_addr_q + 8'd1;
                    vidx_d   = vidx_q + 9'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // A byte accepted on this edge always wins over the timer
        if (TIMEOUT != 16'd0 && !accept && tmr_q == TIMEOUT - 16'd1 &&
            (state_q == S_ADDR || state_q == S_LEN || state_q == S_DATA || state_q == S_CSUM)) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
            code_d  = 2'b10;
            hold_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= 8'd0;
            len_q    <= 9'd0;
            idx_q    <= 9'd0;
            xor_q    <= 8'd0;
            tmr_q    <= 16'd0;
            we_q     <= 1'b0;
            w_addr_q <= 8'd0;
            w_data_q <= 8'd0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 2'b00;
`ifdef PROG_LOADER_VERIFY_EN
            r_addr_q <= 8'd0;
            vidx_q   <= 9'd0;
            vxor_q   <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            tmr_q    <= tmr_d;
            we_q     <= we_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
            code_q   <= code_d;
`ifdef PROG_LOADER_VERIFY_EN
            r_addr_q <= r_addr_d;
            vidx_q   <= vidx_d;
            vxor_q   <= vxor_d;
`endif
        end
    end

endmodule
